// File: rtl/window_line_buffer_if.sv
// Pixel-in / window-out streaming handshake for window_line_buffer.
// The block itself uses the slave view. The pixel source and the window consumer use the master view.
interface window_line_buffer_if #(
    parameter int DSIZE = 8,
    parameter int KSIZE = 3
);
    logic                        in_valid;
    logic                        in_ready;
    logic [DSIZE-1:0]            in_data;
    logic                        out_valid;
    logic                        out_ready;
    logic [KSIZE*KSIZE*DSIZE-1:0] out_window;
    logic                        out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_window, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_window, out_last
    );
endinterface

// File: rtl/window_line_buffer.sv
// KSIZE x KSIZE sliding-window generator over a raster pixel stream.
// Frame size is set at runtime. Only windows that lie fully inside the frame are emitted.
// All storage advances only when a pixel is accepted.
module window_line_buffer #(
    parameter int DSIZE      = 8,
    parameter int MAX_WIDTH  = 256,
    parameter int MAX_HEIGHT = 256,
    parameter int KSIZE      = 3,
    parameter int WW         = $clog2(MAX_WIDTH + 1),
    parameter int HW         = $clog2(MAX_HEIGHT + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_start,
    input  logic [WW-1:0]        cfg_width,
    input  logic [HW-1:0]        cfg_height,
    window_line_buffer_if.slave  s,
    output logic                 busy,
    output logic                 cfg_err
);
    localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
    localparam int WB = KSIZE * KSIZE * DSIZE;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t          state_reg, state_next;
    logic [WW-1:0]   w_reg, w_next;
    logic [HW-1:0]   h_reg, h_next;
    logic [WW-1:0]   col_reg, col_next;
    logic [HW-1:0]   row_reg, row_next;
    logic            out_valid_reg, out_valid_next;
    logic            out_last_reg, out_last_next;
    logic            cfg_err_reg, cfg_err_next;
    logic [WB-1:0]   out_window_reg;
    logic            load_win;

    logic [WB-1:0]              win_reg, win_next;
    logic [(KSIZE-1)*DSIZE-1:0] rd_bus;
    logic [KSIZE*DSIZE-1:0]     col_bus;

    logic            accept, cfg_ok, col_last, row_last, win_ready;
    logic [AW-1:0]   wr_addr, rd_addr;

    assign cfg_ok    = (cfg_width  >= WW'(KSIZE)) && (cfg_width  <= WW'(MAX_WIDTH)) &&
                       (cfg_height >= HW'(KSIZE)) && (cfg_height <= HW'(MAX_HEIGHT));
    assign s.in_ready = (state_reg == ACTIVE) && !frame_start && (!out_valid_reg || s.out_ready);
    assign accept    = s.in_valid && s.in_ready;
    assign col_last  = (col_reg == w_reg - WW'(1));
    assign row_last  = (row_reg == h_reg - HW'(1));
    assign win_ready = (col_reg >= WW'(KSIZE - 1)) && (row_reg >= HW'(KSIZE - 1));

    // The line memories are written at the current column.
    // They are read one cycle ahead at the column of the next pixel, so the read data is registered and ready when that pixel arrives.
    assign wr_addr = AW'(col_reg);
    assign rd_addr = AW'(col_next);

    assign s.out_valid  = out_valid_reg;
    assign s.out_last   = out_last_reg;
    assign s.out_window = out_window_reg;
    assign busy         = (state_reg == ACTIVE);
    assign cfg_err      = cfg_err_reg;

    // The newest pixel forms the bottom row of the incoming column.
    assign col_bus[(KSIZE-1)*DSIZE +: DSIZE] = s.in_data;

    // Line memory gi holds the row gi+1 above the current row.
    // When a pixel is accepted, each line memory passes its entry down to the next one.
    for (genvar gi = 0; gi < KSIZE - 1; gi++) begin : g_line
        logic [DSIZE-1:0] mem [MAX_WIDTH];
        logic [DSIZE-1:0] rd_reg;
        logic [DSIZE-1:0] wr_data;

        if (gi == 0) begin : g_first
            assign wr_data = s.in_data;
        end else begin : g_chain
            assign wr_data = rd_bus[(gi-1)*DSIZE +: DSIZE];
        end

        // Block-RAM style line store: write on accept, registered read every cycle
        always_ff @(posedge clk) begin
            if (accept) begin
                mem[wr_addr] <= wr_data;
            end
            rd_reg <= mem[rd_addr];
        end

        assign rd_bus[gi*DSIZE +: DSIZE]              = rd_reg;
        assign col_bus[(KSIZE-2-gi)*DSIZE +: DSIZE]   = rd_reg;
    end

    // Window shifts left by one column. The rightmost column is taken from the incoming column.
    for (genvar gi = 0; gi < KSIZE * KSIZE; gi++) begin : g_win
        if ((gi % KSIZE) == KSIZE - 1) begin : g_new
            assign win_next[gi*DSIZE +: DSIZE] = col_bus[(gi / KSIZE)*DSIZE +: DSIZE];
        end else begin : g_shift
            assign win_next[gi*DSIZE +: DSIZE] = win_reg[(gi+1)*DSIZE +: DSIZE];
        end
    end

    // Window datapath register. Its contents are don't-care until KSIZE columns have been shifted in.
    always_ff @(posedge clk) begin
        if (accept) begin
            win_reg <= win_next;
        end
    end

    // Next-state logic: frame_start handling, output handshake, raster counters
    always_comb begin
        state_next     = state_reg;
        w_next         = w_reg;
        h_next         = h_reg;
        col_next       = col_reg;
        row_next       = row_reg;
        out_valid_next = out_valid_reg;
        out_last_next  = out_last_reg;
        cfg_err_next   = cfg_err_reg;
        load_win       = 1'b0;

        if (frame_start) begin
            out_valid_next = 1'b0;
            out_last_next  = 1'b0;
            if (cfg_ok) begin
                w_next       = cfg_width;
                h_next       = cfg_height;
                col_next     = '0;
                row_next     = '0;
                cfg_err_next = 1'b0;
                state_next   = ACTIVE;
            end else begin
                cfg_err_next = 1'b1;
                state_next   = IDLE;
            end
        end else begin
            if (out_valid_reg && s.out_ready) begin
                out_valid_next = 1'b0;
                out_last_next  = 1'b0;
            end
            if (accept) begin
                if (col_last) begin
                    col_next = '0;
                    row_next = row_reg + HW'(1);
                end else begin
                    col_next = col_reg + WW'(1);
                end
                if (win_ready) begin
                    load_win       = 1'b1;
                    out_valid_next = 1'b1;
                    out_last_next  = col_last && row_last;
                end
                if (col_last && row_last) begin
                    state_next = IDLE;
                end
            end
        end
    end

    // Control and output registers. All of them return to their reset values as soon as reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            w_reg          <= '0;
            h_reg          <= '0;
            col_reg        <= '0;
            row_reg        <= '0;
            out_valid_reg  <= 1'b0;
            out_last_reg   <= 1'b0;
            cfg_err_reg    <= 1'b0;
            out_window_reg <= '0;
        end else begin
            state_reg     <= state_next;
            w_reg         <= w_next;
            h_reg         <= h_next;
            col_reg       <= col_next;
            row_reg       <= row_next;
            out_valid_reg <= out_valid_next;
            out_last_reg  <= out_last_next;
            cfg_err_reg   <= cfg_err_next;
            if (load_win) begin
                out_window_reg <= win_next;
            end
        end
    end
endmodule
